// File: rtl/arp_lookup_seq.sv
// rtl/arp_lookup_seq.sv - next-hop ARP resolution: request FIFO, sequential table search, register port
module arp_lookup_seq #(
  parameter int NUM_QUEUES     = 5,
  parameter int ARP_DEPTH      = 32,
  parameter int ARP_DEPTH_BITS = 5,
  parameter int REQ_FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               next_hop_ip,
  input  logic [NUM_QUEUES-1:0]     lpm_output_port,
  input  logic                      lpm_vld,
  input  logic                      lpm_hit,
  output logic [47:0]               arp_mac,
  output logic [NUM_QUEUES-1:0]     arp_output_port,
  output logic                      arp_lpm_hit,
  output logic                      arp_hit,
  output logic                      arp_vld,
  output logic                      arp_req_drop,
  input  logic [ARP_DEPTH_BITS-1:0] arp_rd_addr,
  input  logic                      arp_rd_req,
  output logic [31:0]               arp_rd_ip,
  output logic [47:0]               arp_rd_mac,
  output logic                      arp_rd_ack,
  input  logic [ARP_DEPTH_BITS-1:0] arp_wr_addr,
  input  logic                      arp_wr_req,
  input  logic [31:0]               arp_wr_ip,
  input  logic [47:0]               arp_wr_mac,
  output logic                      arp_wr_ack
);

  localparam int FIFO_AW = $clog2(REQ_FIFO_DEPTH);
  localparam int REQ_W   = 32 + NUM_QUEUES + 1;
  localparam logic [FIFO_AW:0]        FIFO_FULL = (FIFO_AW+1)'(REQ_FIFO_DEPTH);
  localparam logic [ARP_DEPTH_BITS-1:0] IDX_LAST = ARP_DEPTH_BITS'(ARP_DEPTH - 1);

  typedef enum logic {IDLE, SEARCH} state_t;

  // request FIFO, entries packed as {ip, port, lpm_hit}
  logic [REQ_W-1:0]   fifo_q [REQ_FIFO_DEPTH];
  logic [REQ_W-1:0]   fifo_d [REQ_FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;

  logic [31:0] tbl_ip_q  [ARP_DEPTH];
  logic [31:0] tbl_ip_d  [ARP_DEPTH];
  logic [47:0] tbl_mac_q [ARP_DEPTH];
  logic [47:0] tbl_mac_d [ARP_DEPTH];

  state_t                    state_q, state_d;
  logic [ARP_DEPTH_BITS-1:0] idx_q, idx_d;
  logic [31:0]               cur_ip_q, cur_ip_d;
  logic [NUM_QUEUES-1:0]     cur_port_q, cur_port_d;

  logic                      wr_pend_q, wr_pend_d;
  logic [ARP_DEPTH_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]               wr_ip_q, wr_ip_d;
  logic [47:0]               wr_mac_q, wr_mac_d;

  logic [47:0]           arp_mac_q, arp_mac_d;
  logic [NUM_QUEUES-1:0] arp_port_q, arp_port_d;
  logic                  arp_lpm_hit_q, arp_lpm_hit_d;
  logic                  arp_hit_q, arp_hit_d;
  logic                  arp_vld_q, arp_vld_d;
  logic                  arp_drop_q, arp_drop_d;
  logic [31:0]           rd_ip_q, rd_ip_d;
  logic [47:0]           rd_mac_q, rd_mac_d;
  logic                  rd_ack_q, rd_ack_d;
  logic                  wr_ack_q, wr_ack_d;

  logic                  pop, push, wr_apply, entry_match;
  logic [31:0]           head_ip;
  logic [NUM_QUEUES-1:0] head_port;
  logic                  head_hit;

  always_comb begin
    fifo_d        = fifo_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    cnt_d         = cnt_q;
    tbl_ip_d      = tbl_ip_q;
    tbl_mac_d     = tbl_mac_q;
    state_d       = state_q;
    idx_d         = idx_q;
    cur_ip_d      = cur_ip_q;
    cur_port_d    = cur_port_q;
    wr_pend_d     = wr_pend_q;
    wr_addr_d     = wr_addr_q;
    wr_ip_d       = wr_ip_q;
    wr_mac_d      = wr_mac_q;
    arp_mac_d     = arp_mac_q;
    arp_port_d    = arp_port_q;
    arp_lpm_hit_d = arp_lpm_hit_q;
    arp_hit_d     = arp_hit_q;
    arp_vld_d     = 1'b0;
    rd_ip_d       = rd_ip_q;
    rd_mac_d      = rd_mac_q;
    rd_ack_d      = arp_rd_req;

    head_ip     = fifo_q[rd_ptr_q][REQ_W-1 -: 32];
    head_port   = fifo_q[rd_ptr_q][NUM_QUEUES:1];
    head_hit    = fifo_q[rd_ptr_q][0];
    entry_match = (tbl_ip_q[idx_q] != 32'd0) && (tbl_ip_q[idx_q] == cur_ip_q);

    // a pop frees a slot in the same cycle, so a full FIFO still accepts then
    pop        = (state_q == IDLE) && (cnt_q != '0);
    push       = lpm_vld && ((cnt_q != FIFO_FULL) || pop);
    arp_drop_d = lpm_vld && !push;

    if (push) begin
      fifo_d[wr_ptr_q] = {next_hop_ip, lpm_output_port, lpm_hit};
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    // read sees the table as it was before any write landing this edge
    if (arp_rd_req) begin
      rd_ip_d  = tbl_ip_q[arp_rd_addr];
      rd_mac_d = tbl_mac_q[arp_rd_addr];
    end

    // writes are held off while searching so the search sees a stable table
    wr_apply = wr_pend_q && (state_q != SEARCH);
    wr_ack_d = wr_apply;
    if (!wr_pend_q) begin
      if (arp_wr_req) begin
        wr_pend_d = 1'b1;
        wr_addr_d = arp_wr_addr;
        wr_ip_d   = arp_wr_ip;
        wr_mac_d  = arp_wr_mac;
      end
    end else if (wr_apply) begin
      tbl_ip_d[wr_addr_q]  = wr_ip_q;
      tbl_mac_d[wr_addr_q] = wr_mac_q;
      wr_pend_d            = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (pop) begin
          cur_ip_d   = head_ip;
          cur_port_d = head_port;
          if (head_hit) begin
            state_d = SEARCH;
            idx_d   = '0;
          end else begin
            arp_vld_d     = 1'b1;
            arp_hit_d     = 1'b0;
            arp_mac_d     = 48'd0;
            arp_port_d    = head_port;
            arp_lpm_hit_d = 1'b0;
          end
        end
      end
      SEARCH: begin
        if (entry_match || (idx_q == IDX_LAST)) begin
          arp_vld_d     = 1'b1;
          arp_hit_d     = entry_match;
          arp_mac_d     = entry_match ? tbl_mac_q[idx_q] : 48'd0;
          arp_port_d    = cur_port_q;
          arp_lpm_hit_d = 1'b1;
          state_d       = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REQ_FIFO_DEPTH; i++) fifo_q[i] <= '0;
      for (int i = 0; i < ARP_DEPTH; i++) begin
        tbl_ip_q[i]  <= '0;
        tbl_mac_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      state_q       <= IDLE;
      idx_q         <= '0;
      cur_ip_q      <= '0;
      cur_port_q    <= '0;
      wr_pend_q     <= 1'b0;
      wr_addr_q     <= '0;
      wr_ip_q       <= '0;
      wr_mac_q      <= '0;
      arp_mac_q     <= '0;
      arp_port_q    <= '0;
      arp_lpm_hit_q <= 1'b0;
      arp_hit_q     <= 1'b0;
      arp_vld_q     <= 1'b0;
      arp_drop_q    <= 1'b0;
      rd_ip_q       <= '0;
      rd_mac_q      <= '0;
      rd_ack_q      <= 1'b0;
      wr_ack_q      <= 1'b0;
    end else begin
      fifo_q        <= fifo_d;
      tbl_ip_q      <= tbl_ip_d;
      tbl_mac_q     <= tbl_mac_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      idx_q         <= idx_d;
      cur_ip_q      <= cur_ip_d;
      cur_port_q    <= cur_port_d;
      wr_pend_q     <= wr_pend_d;
      wr_addr_q     <= wr_addr_d;
      wr_ip_q       <= wr_ip_d;
      wr_mac_q      <= wr_mac_d;
      arp_mac_q     <= arp_mac_d;
      arp_port_q    <= arp_port_d;
      arp_lpm_hit_q <= arp_lpm_hit_d;
      arp_hit_q     <= arp_hit_d;
      arp_vld_q     <= arp_vld_d;
      arp_drop_q    <= arp_drop_d;
      rd_ip_q       <= rd_ip_d;
      rd_mac_q      <= rd_mac_d;
      rd_ack_q      <= rd_ack_d;
      wr_ack_q      <= wr_ack_d;
    end
  end

  assign arp_mac         = arp_mac_q;
  assign arp_output_port = arp_port_q;
  assign arp_lpm_hit     = arp_lpm_hit_q;
  assign arp_hit         = arp_hit_q;
  assign arp_vld         = arp_vld_q;
  assign arp_req_drop    = arp_drop_q;
  assign arp_rd_ip       = rd_ip_q;
  assign arp_rd_mac      = rd_mac_q;
  assign arp_rd_ack      = rd_ack_q;
  assign arp_wr_ack      = wr_ack_q;

endmodule

// File: tb/tb_arp_lookup_seq.sv
// tb/tb_arp_lookup_seq.sv - scoreboard bench for arp_lookup_seq with reference table model
module tb_arp_lookup_seq;
  localparam int NQ = 5;
  localparam int AD = 32;
  localparam int AB = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   next_hop_ip;
  logic [NQ-1:0] lpm_output_port;
  logic          lpm_vld, lpm_hit;
  logic [47:0]   arp_mac;
  logic [NQ-1:0] arp_output_port;
  logic          arp_lpm_hit, arp_hit, arp_vld, arp_req_drop;
  logic [AB-1:0] arp_rd_addr;
  logic          arp_rd_req;
  logic [31:0]   arp_rd_ip;
  logic [47:0]   arp_rd_mac;
  logic          arp_rd_ack;
  logic [AB-1:0] arp_wr_addr;
  logic          arp_wr_req;
  logic [31:0]   arp_wr_ip;
  logic [47:0]   arp_wr_mac;
  logic          arp_wr_ack;

  always #5 clk = ~clk;

  arp_lookup_seq dut (
    .clk(clk), .reset(reset),
    .next_hop_ip(next_hop_ip), .lpm_output_port(lpm_output_port),
    .lpm_vld(lpm_vld), .lpm_hit(lpm_hit),
    .arp_mac(arp_mac), .arp_output_port(arp_output_port),
    .arp_lpm_hit(arp_lpm_hit), .arp_hit(arp_hit), .arp_vld(arp_vld),
    .arp_req_drop(arp_req_drop),
    .arp_rd_addr(arp_rd_addr), .arp_rd_req(arp_rd_req),
    .arp_rd_ip(arp_rd_ip), .arp_rd_mac(arp_rd_mac), .arp_rd_ack(arp_rd_ack),
    .arp_wr_addr(arp_wr_addr), .arp_wr_req(arp_wr_req),
    .arp_wr_ip(arp_wr_ip), .arp_wr_mac(arp_wr_mac), .arp_wr_ack(arp_wr_ack)
  );

  typedef struct {
    logic [47:0]   mac;
    logic          hit;
    logic          lpm_hit;
    logic [NQ-1:0] port;
    int            lat;
    int            issue;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          drops = 0;
  int          last_vld_cyc = -1;
  logic [31:0] m_ip  [AD];
  logic [47:0] m_mac [AD];
  logic [31:0] pool  [6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_find(input logic [31:0] ip);
    for (int i = 0; i < AD; i++)
      if (m_ip[i] != 32'd0 && m_ip[i] == ip) return i;
    return -1;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      if (arp_req_drop) drops++;
      if (arp_vld) begin
        last_vld_cyc = cyc;
        if (sb.size() == 0) begin
          chk("unexpected_vld", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("arp_hit", arp_hit, e.hit);
          chk("arp_mac", arp_mac, e.mac);
          chk("arp_lpm_hit", arp_lpm_hit, e.lpm_hit);
          chk("arp_output_port", arp_output_port, e.port);
          if (e.lat >= 0) chk("latency", cyc - e.issue, e.lat);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // all stimulus tasks start and end 1 time unit after a rising edge
  task automatic lookup(input logic [31:0] ip, input logic hit, input logic [NQ-1:0] port,
                        input bit timed, input bit expect_result);
    exp_t e;
    int   k;
    next_hop_ip = ip; lpm_hit = hit; lpm_output_port = port; lpm_vld = 1'b1;
    k = model_find(ip);
    e.port = port; e.lpm_hit = hit; e.issue = cyc;
    if (!hit)        begin e.hit = 1'b0; e.mac = 48'd0;    e.lat = 2;      end
    else if (k >= 0) begin e.hit = 1'b1; e.mac = m_mac[k]; e.lat = k + 3;  end
    else             begin e.hit = 1'b0; e.mac = 48'd0;    e.lat = AD + 2; end
    if (!timed) e.lat = -1;
    if (expect_result) sb.push_back(e);
    tick(1);
    lpm_vld = 1'b0;
  endtask

  task automatic tbl_write(input int a, input logic [31:0] ip, input logic [47:0] mac, input int exp_lat);
    int start, n;
    arp_wr_addr = AB'(a); arp_wr_ip = ip; arp_wr_mac = mac; arp_wr_req = 1'b1;
    start = cyc;
    tick(1);
    arp_wr_req = 1'b0;
    n = 0;
    while (arp_wr_ack !== 1'b1 && n < 100) begin tick(1); n++; end
    if (n >= 100) chk("wr_ack_timeout", 64'd0, 64'd1);
    else if (exp_lat >= 0) chk("wr_ack_latency", cyc - start, exp_lat);
    m_ip[a] = ip; m_mac[a] = mac;
    tick(1);
    chk("wr_ack_pulse", arp_wr_ack, 1'b0);
  endtask

  task automatic tbl_read(input int a);
    arp_rd_addr = AB'(a); arp_rd_req = 1'b1;
    tick(1);
    arp_rd_req = 1'b0;
    chk("rd_ack", arp_rd_ack, 1'b1);
    chk("rd_ip", arp_rd_ip, m_ip[a]);
    chk("rd_mac", arp_rd_mac, m_mac[a]);
    tick(1);
    chk("rd_ack_pulse", arp_rd_ack, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin tick(1); n++; end
    chk("drain", sb.size(), 0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    for (int i = 0; i < AD; i++) begin m_ip[i] = '0; m_mac[i] = '0; end
    sb.delete();
    tick(2);
    reset = 1'b0;
  endtask

  function automatic logic [NQ-1:0] rand_port();
    logic [NQ-1:0] p = '0;
    p[$urandom_range(0, NQ-1)] = 1'b1;
    return p;
  endfunction

  task automatic random_round(input int n_wr, input int n_lk);
    logic [31:0] ip;
    for (int i = 0; i < n_wr; i++)
      tbl_write($urandom_range(0, AD-1), pool[$urandom_range(0, 5)], {$urandom, $urandom}, 2);
    for (int i = 0; i < n_lk; i++) begin
      while (sb.size() >= 4) tick(1);
      tick($urandom_range(0, 2));
      ip = ($urandom_range(0, 4) == 0) ? $urandom : pool[$urandom_range(0, 5)];
      lookup(ip, 1'($urandom_range(0, 3) != 0), rand_port(), 1'b0, 1'b1);
    end
    drain();
  endtask

  initial begin : watchdog
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    next_hop_ip = '0; lpm_output_port = '0; lpm_vld = 1'b0; lpm_hit = 1'b0;
    arp_rd_addr = '0; arp_rd_req = 1'b0;
    arp_wr_addr = '0; arp_wr_req = 1'b0; arp_wr_ip = '0; arp_wr_mac = '0;
    for (int i = 0; i < AD; i++) begin m_ip[i] = '0; m_mac[i] = '0; end
    pool[0] = 32'd0;
    for (int i = 1; i < 6; i++) pool[i] = 32'hC0A8_0000 | 32'(i);
    @(posedge clk);
    tick(2);
    reset = 1'b0;

    chk("rst_vld", arp_vld, 1'b0);
    chk("rst_hit", arp_hit, 1'b0);
    chk("rst_mac", arp_mac, 48'd0);
    chk("rst_port", arp_output_port, '0);
    chk("rst_lpm_hit", arp_lpm_hit, 1'b0);
    chk("rst_drop", arp_req_drop, 1'b0);
    chk("rst_rd", {arp_rd_ack, arp_rd_ip, arp_rd_mac[15:0]}, '0);
    chk("rst_wr_ack", arp_wr_ack, 1'b0);
    tick(2);

    // directed hit at index 3
    tbl_write(3, 32'h0A00_0001, 48'h0011_2233_4455, 2);
    lookup(32'h0A00_0001, 1'b1, 5'b00100, 1'b1, 1'b1);
    drain();

    // full-table miss, last-index hit, lpm miss bypass
    lookup(32'h0A00_0009, 1'b1, 5'b00010, 1'b1, 1'b1);
    drain();
    tbl_write(31, 32'h0A00_001F, 48'hAABB_CCDD_EEFF, 2);
    lookup(32'h0A00_001F, 1'b1, 5'b10000, 1'b1, 1'b1);
    drain();
    lookup(32'h0A00_0001, 1'b0, 5'b01000, 1'b1, 1'b1);
    drain();
    lookup(32'h0000_0000, 1'b1, 5'b00001, 1'b1, 1'b1);
    drain();

    // six back-to-back requests while a miss search is running
    lookup(32'h0A00_0009, 1'b1, 5'b00001, 1'b1, 1'b1);
    tick(2);
    for (int i = 0; i < 6; i++)
      lookup((i % 2) ? 32'h0A00_0001 : 32'h0A00_001F, 1'(i != 2), rand_port(), 1'b0, i < 4);
    drain();
    chk("drop_count_burst", drops, 2);

    // write during a search is deferred until after its result
    lookup(32'h0A00_0055, 1'b1, 5'b00010, 1'b1, 1'b1);
    tick(4);
    tbl_write(20, 32'h0A00_0055, 48'h1234_5678_9ABC, 30);
    chk("wr_ack_after_vld", (last_vld_cyc >= 0) && (cyc > last_vld_cyc), 1'b1);
    drain();
    tbl_read(20);
    lookup(32'h0A00_0055, 1'b1, 5'b00100, 1'b1, 1'b1);
    drain();

    // same-cycle read and write of one address returns old contents
    arp_rd_addr = 5'd3; arp_rd_req = 1'b1;
    arp_wr_addr = 5'd3; arp_wr_req = 1'b1; arp_wr_ip = 32'h0A00_0077; arp_wr_mac = 48'h0000_0000_0077;
    tick(1);
    arp_rd_req = 1'b0; arp_wr_req = 1'b0;
    chk("rdwr_same_ip", arp_rd_ip, m_ip[3]);
    chk("rdwr_same_mac", arp_rd_mac, m_mac[3]);
    tick(1);
    chk("rdwr_wr_ack", arp_wr_ack, 1'b1);
    m_ip[3] = 32'h0A00_0077; m_mac[3] = 48'h0000_0000_0077;
    tbl_read(3);

    // duplicate IP: lowest index wins
    tbl_write(2, 32'h0A00_00D0, 48'h0000_0000_0002, 2);
    tbl_write(7, 32'h0A00_00D0, 48'h0000_0000_0007, 2);
    lookup(32'h0A00_00D0, 1'b1, 5'b01000, 1'b1, 1'b1);
    drain();

    // reset in the middle of a search: no result, table cleared
    lookup(32'h0A00_0099, 1'b1, 5'b00001, 1'b0, 1'b0);
    tick(10);
    apply_reset();
    tick(40);
    tbl_read(2);
    tbl_read(7);
    chk("rst_vld_after", arp_vld, 1'b0);

    random_round(10, 40);
    random_round(12, 40);
    chk("drop_count_total", drops, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
